// File: rtl/rssi_report_packer.sv
// rssi_report_packer
//   Holds the newest RSSI / raw-dB / gain result from the datapath. Every
//   REPORT_PERIOD_MS millisecond ticks it turns that result into a short byte
//   packet and pushes the bytes into the UART TX FIFO, one byte per cycle
//   whenever the FIFO is not full.
//
//   Packet: SYNC_BYTE, seq, gain, rssi[15:8], rssi[7:0], raw[15:8], raw[7:0]
//   and, when REPORT_CHECKSUM_EN is defined, a trailing XOR of bytes 1..6.
//   Without REPORT_CHECKSUM_EN the packet is 7 bytes and has no checksum.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   en_i            allows new packet launches (a packet in flight always finishes)
//   ms_en_i         one-cycle millisecond tick
//   rssi_i          RSSI result, RSSI_W bits, zero-extended to 16 in the packet
//   raw_db_i        raw ADC dB result
//   gain_db_i       PGA gain in dB
//   valid_i         one-cycle strobe qualifying rssi_i / raw_db_i / gain_db_i
//   fifo_full_i     UART TX FIFO full
//   data_o          byte to the FIFO (0 when not sending)
//   wr_en_o         FIFO write strobe
//   busy_o          a packet is being sent
//   seq_o           sequence number of the next packet
//   dropped_o       results overwritten before being sent (saturates at 255)
//   state_dbg       current FSM state (0 = IDLE, 1 = SEND)
//
// Handshake: a byte is transferred on every cycle where wr_en_o is high.
// wr_en_o is simply "sending and FIFO not full"; the byte index only moves on
// such a cycle, so a full FIFO holds the current byte in place for as long as
// it stays full, with no loss and no repeat.

module rssi_report_packer #(
  parameter int         REPORT_PERIOD_MS = 100,
  parameter int         RSSI_W           = 16,
  parameter logic [7:0] SYNC_BYTE        = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              ms_en_i,
  input  logic [RSSI_W-1:0] rssi_i,
  input  logic [15:0]       raw_db_i,
  input  logic [7:0]        gain_db_i,
  input  logic              valid_i,
  input  logic              fifo_full_i,
  output logic [7:0]        data_o,
  output logic              wr_en_o,
  output logic              busy_o,
  output logic [7:0]        seq_o,
  output logic [7:0]        dropped_o,
  output logic [0:0]        state_dbg
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

`ifdef REPORT_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd7;
`else
  localparam logic [2:0] LAST_IDX = 3'd6;
`endif

  localparam int                CNT_W     = (REPORT_PERIOD_MS > 1) ? $clog2(REPORT_PERIOD_MS) : 1;
  localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(REPORT_PERIOD_MS - 1);

  logic [0:0]       state;
  logic [2:0]       idx;
  logic [7:0]       seq;
  logic [7:0]       dropped;
  logic             pending;
  logic             elapsed;
  logic [CNT_W-1:0] tick_cnt;

  logic [15:0]      sh_rssi;
  logic [15:0]      sh_raw;
  logic [7:0]       sh_gain;
  logic [15:0]      pk_rssi;
  logic [15:0]      pk_raw;
  logic [7:0]       pk_gain;

  logic [15:0]      rssi_ext;
  logic             launch;
  logic             period_done;
  logic             write;
  logic [7:0]       cur_byte;

  assign rssi_ext    = 16'(rssi_i);
  assign launch      = (state == IDLE) && en_i && pending && elapsed;
  assign period_done = ms_en_i && (tick_cnt == LAST_TICK);
  assign write       = (state == SEND) && !fifo_full_i;

`ifdef REPORT_CHECKSUM_EN
  logic [7:0] checksum;
  assign checksum = seq ^ pk_gain ^ pk_rssi[15:8] ^ pk_rssi[7:0] ^
                    pk_raw[15:8] ^ pk_raw[7:0];
`endif

  always_comb begin
    cur_byte = 8'h00;
    case (idx)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = seq;
      3'd2:    cur_byte = pk_gain;
      3'd3:    cur_byte = pk_rssi[15:8];
      3'd4:    cur_byte = pk_rssi[7:0];
      3'd5:    cur_byte = pk_raw[15:8];
      3'd6:    cur_byte = pk_raw[7:0];
`ifdef REPORT_CHECKSUM_EN
      3'd7:    cur_byte = checksum;
`endif
      default: cur_byte = 8'h00;
    endcase
  end

  assign data_o    = (state == SEND) ? cur_byte : 8'h00;
  assign wr_en_o   = write;
  assign busy_o    = (state == SEND);
  assign seq_o     = seq;
  assign dropped_o = dropped;
  assign state_dbg = state;

  // Millisecond tick counter. Runs regardless of busy/en_i so the report
  // cadence never drifts. A period finishing on the launch cycle re-arms
  // elapsed rather than being lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      elapsed  <= 1'b0;
    end else begin
      if (ms_en_i) begin
        tick_cnt <= period_done ? '0 : tick_cnt + 1'b1;
      end
      if (period_done) begin
        elapsed <= 1'b1;
      end else if (launch) begin
        elapsed <= 1'b0;
      end
    end
  end

  // Shadow registers and the pending/dropped bookkeeping. A result arriving
  // on the launch cycle goes straight into the packet, so it neither sets
  // pending nor counts as a drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_rssi <= 16'h0000;
      sh_raw  <= 16'h0000;
      sh_gain <= 8'h00;
      pending <= 1'b0;
      dropped <= 8'h00;
    end else begin
      if (valid_i) begin
        sh_rssi <= rssi_ext;
        sh_raw  <= raw_db_i;
        sh_gain <= gain_db_i;
      end
      if (launch) begin
        pending <= 1'b0;
      end else if (valid_i) begin
        pending <= 1'b1;
        if (pending && (dropped != 8'hFF)) begin
          dropped <= dropped + 8'd1;
        end
      end
    end
  end

  // Packet FSM: IDLE waits for a launch, SEND walks the byte index on each
  // accepted write and bumps seq after the last byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= 3'd0;
      seq     <= 8'h00;
      pk_rssi <= 16'h0000;
      pk_raw  <= 16'h0000;
      pk_gain <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            pk_rssi <= valid_i ? rssi_ext  : sh_rssi;
            pk_raw  <= valid_i ? raw_db_i  : sh_raw;
            pk_gain <= valid_i ? gain_db_i : sh_gain;
            idx     <= 3'd0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (write) begin
            if (idx == LAST_IDX) begin
              idx   <= 3'd0;
              seq   <= seq + 8'd1;
              state <= IDLE;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
